// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  // Default fetch address after reset (word-aligned).
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  // Sequencer control states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_buf.sv
// ============================================================================
// Module      : pc_redirect_buf
// Description : One-entry pending-redirect register. A redirect seen while
//               the pipeline is stalled is parked here; a later capture
//               overwrites it (youngest wins) and a consume empties it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_buf
  import pc_seq_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        capture_i,
  input  logic [31:0] target_i,
  input  logic        consume_i,
  output logic        valid_o,
  output logic [31:0] target_o
);

  logic        valid_q, valid_d;
  logic [31:0] target_q, target_d;

  // Capture has priority over consume; the two are exclusive in practice.
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (capture_i) begin
      valid_d  = 1'b1;
      target_d = target_i;
    end else if (consume_i) begin
      valid_d  = 1'b0;
    end
  end

  // Pending entry storage with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      valid_q  <= 1'b0;
      target_q <= 32'h0000_0000;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer. Advances the PC, applies branch /
//               jump redirects with a one-cycle latency, holds on stall while
//               parking redirects, and locks up on misaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        stall_i,
  input  logic [31:0] pc_plus_4_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        if_id_flush_o,
  output logic        misaligned_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        flush;
  logic        capture;
  logic        consume;

  logic        w_pend_valid;
  logic [31:0] w_pend_target;
  logic        w_redirect;
  logic [31:0] w_new_target;
  logic [31:0] w_sel_target;
  logic        w_active;
  logic        w_take;
  logic        w_bad;

  // Branch wins over jump when both fire; that case is legal.
  assign w_redirect   = branch_taken_i | jump_i;
  assign w_new_target = branch_taken_i ? branch_target_i : jump_target_i;
  // A fresh redirect outranks the parked one.
  assign w_sel_target = w_redirect ? w_new_target : w_pend_target;
  assign w_active     = (state_q == RUN) || (state_q == HOLD);
  assign w_take       = w_active && !stall_i && (w_redirect || w_pend_valid);
  assign w_bad        = w_take && (w_sel_target[1:0] != 2'b00);

  pc_redirect_buf u_redirect_buf (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .capture_i (capture),
    .target_i  (w_new_target),
    .consume_i (consume),
    .valid_o   (w_pend_valid),
    .target_o  (w_pend_target)
  );

  // State and datapath registers; reset returns to BOOT at RESET_PC.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // Next-state selection: BOOT lasts one cycle, ERR is absorbing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:      state_d = RUN;
      RUN, HOLD: begin
        if (stall_i)    state_d = HOLD;
        else if (w_bad) state_d = ERR;
        else            state_d = RUN;
      end
      ERR:       state_d = ERR;
      default:   state_d = BOOT;
    endcase
  end

  // Datapath updates and control strobes for the current state.
  always_comb begin
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    misaligned_d  = misaligned_q;
    flush         = 1'b0;
    capture       = 1'b0;
    consume       = 1'b0;
    case (state_q)
      BOOT: begin
        pc_d          = RESET_PC;
        fetch_valid_d = 1'b0;
      end
      RUN, HOLD: begin
        if (stall_i) begin
          fetch_valid_d = 1'b0;
          capture       = w_redirect;
        end else if (w_bad) begin
          // Target rejected: PC stays put and the error is latched.
          fetch_valid_d = 1'b0;
          misaligned_d  = 1'b1;
          consume       = w_pend_valid;
        end else if (w_take) begin
          pc_d          = w_sel_target;
          fetch_valid_d = 1'b1;
          flush         = 1'b1;
          consume       = w_pend_valid;
        end else begin
          pc_d          = pc_plus_4_i;
          fetch_valid_d = 1'b1;
        end
      end
      ERR: begin
        fetch_valid_d = 1'b0;
      end
      default: begin
        fetch_valid_d = 1'b0;
      end
    endcase
    // No squash may be signalled while reset is asserted.
    if (!reset_n_i) begin
      flush = 1'b0;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign if_id_flush_o = flush;
  assign misaligned_o  = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Each cycle pushes the
//               expected flush (this cycle) and pc/fetch_valid/misaligned
//               (after the edge) into a scoreboard; each scenario task then
//               pops and compares them against what the DUT produced.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        flush;
  } rec_t;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic [31:0] pc_plus_4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        if_id_flush;
  logic        misaligned;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clock_i         (clock),
    .reset_n_i       (reset_n),
    .stall_i         (stall),
    .pc_plus_4_i     (pc_plus_4),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .pc_o            (pc),
    .fetch_valid_o   (fetch_valid),
    .if_id_flush_o   (if_id_flush),
    .misaligned_o    (misaligned)
  );

  // The external PC adder.
  assign pc_plus_4 = pc + 32'd4;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle: drive inputs, record expectation, sample flush mid-cycle
  // and the registered outputs just after the rising edge.
  task automatic drive(input logic rstn, input logic stl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic [31:0] e_pc, input logic e_fv,
                       input logic e_mis, input logic e_flush);
    rec_t e;
    rec_t o;
    reset_n       = rstn;
    stall         = stl;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    e.pc = e_pc; e.fv = e_fv; e.mis = e_mis; e.flush = e_flush;
    exp_q.push_back(e);
    @(negedge clock);
    o.flush = if_id_flush;
    @(posedge clock);
    #1;
    o.pc  = pc;
    o.fv  = fetch_valid;
    o.mis = misaligned;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    rec_t e, o;
    int k = 0;
    drive(0, 0, 1, 32'h40, 0, 32'h0, 32'h0, 0, 0, 0);   // flush gated by reset
    drive(1, 0, 0, 32'h0,  0, 32'h0, 32'h0, 0, 0, 0);   // BOOT
    drive(1, 0, 0, 32'h0,  0, 32'h0, 32'h4, 1, 0, 0);
    drive(1, 0, 0, 32'h0,  0, 32'h0, 32'h8, 1, 0, 0);
    drive(1, 0, 0, 32'h0,  0, 32'h0, 32'hC, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pc !== e.pc)       begin n_bad++; $display("FAIL reset pc[%0d]: got %h want %h", k, o.pc, e.pc); end
      n_cmp++; if (o.fv !== e.fv)       begin n_bad++; $display("FAIL reset fetch_valid[%0d]: got %b want %b", k, o.fv, e.fv); end
      n_cmp++; if (o.mis !== e.mis)     begin n_bad++; $display("FAIL reset misaligned[%0d]: got %b want %b", k, o.mis, e.mis); end
      n_cmp++; if (o.flush !== e.flush) begin n_bad++; $display("FAIL reset flush[%0d]: got %b want %b", k, o.flush, e.flush); end
      k++;
    end
  endtask

  task automatic test_branch();
    rec_t e, o;
    int k = 0;
    drive(1, 0, 0, 32'h0,  0, 32'h0, 32'h10, 1, 0, 0);
    drive(1, 0, 1, 32'h40, 0, 32'h0, 32'h40, 1, 0, 1);
    drive(1, 0, 0, 32'h0,  0, 32'h0, 32'h44, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pc !== e.pc)       begin n_bad++; $display("FAIL branch pc[%0d]: got %h want %h", k, o.pc, e.pc); end
      n_cmp++; if (o.fv !== e.fv)       begin n_bad++; $display("FAIL branch fetch_valid[%0d]: got %b want %b", k, o.fv, e.fv); end
      n_cmp++; if (o.mis !== e.mis)     begin n_bad++; $display("FAIL branch misaligned[%0d]: got %b want %b", k, o.mis, e.mis); end
      n_cmp++; if (o.flush !== e.flush) begin n_bad++; $display("FAIL branch flush[%0d]: got %b want %b", k, o.flush, e.flush); end
      k++;
    end
  endtask

  task automatic test_stall_pending();
    rec_t e, o;
    int k = 0;
    drive(1, 0, 0, 32'h0,   1, 32'h20,  32'h20,  1, 0, 1);
    drive(1, 1, 0, 32'h0,   0, 32'h0,   32'h20,  0, 0, 0);
    drive(1, 1, 0, 32'h0,   1, 32'h80,  32'h20,  0, 0, 0);
    drive(1, 1, 1, 32'h90,  0, 32'h0,   32'h20,  0, 0, 0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h90,  1, 0, 1);   // youngest pending applied
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h94,  1, 0, 0);
    drive(1, 0, 1, 32'h100, 1, 32'h200, 32'h100, 1, 0, 1);   // branch wins over jump
    drive(1, 1, 0, 32'h0,   0, 32'h0,   32'h100, 0, 0, 0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h104, 1, 0, 0);   // release, nothing pending
    drive(1, 1, 0, 32'h0,   1, 32'h300, 32'h104, 0, 0, 0);
    drive(1, 0, 1, 32'h400, 0, 32'h0,   32'h400, 1, 0, 1);   // new redirect beats pending
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h404, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pc !== e.pc)       begin n_bad++; $display("FAIL stall pc[%0d]: got %h want %h", k, o.pc, e.pc); end
      n_cmp++; if (o.fv !== e.fv)       begin n_bad++; $display("FAIL stall fetch_valid[%0d]: got %b want %b", k, o.fv, e.fv); end
      n_cmp++; if (o.mis !== e.mis)     begin n_bad++; $display("FAIL stall misaligned[%0d]: got %b want %b", k, o.mis, e.mis); end
      n_cmp++; if (o.flush !== e.flush) begin n_bad++; $display("FAIL stall flush[%0d]: got %b want %b", k, o.flush, e.flush); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    int k = 0;
    drive(1, 0, 1, 32'h500, 0, 32'h0,         32'h500,       1, 0, 1);
    drive(1, 0, 0, 32'h0,   1, 32'h600,       32'h600,       1, 0, 1);
    drive(1, 0, 0, 32'h0,   1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 1);
    drive(1, 0, 0, 32'h0,   0, 32'h0,         32'h0,         1, 0, 0);   // wrap is legal
    drive(1, 0, 0, 32'h0,   0, 32'h0,         32'h4,         1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pc !== e.pc)       begin n_bad++; $display("FAIL b2b pc[%0d]: got %h want %h", k, o.pc, e.pc); end
      n_cmp++; if (o.fv !== e.fv)       begin n_bad++; $display("FAIL b2b fetch_valid[%0d]: got %b want %b", k, o.fv, e.fv); end
      n_cmp++; if (o.mis !== e.mis)     begin n_bad++; $display("FAIL b2b misaligned[%0d]: got %b want %b", k, o.mis, e.mis); end
      n_cmp++; if (o.flush !== e.flush) begin n_bad++; $display("FAIL b2b flush[%0d]: got %b want %b", k, o.flush, e.flush); end
      k++;
    end
  endtask

  task automatic test_reset_in_hold();
    rec_t e, o;
    int k = 0;
    drive(1, 1, 0, 32'h0,   1, 32'h700, 32'h4, 0, 0, 0);
    drive(1, 1, 0, 32'h0,   0, 32'h0,   32'h4, 0, 0, 0);
    drive(0, 1, 1, 32'h800, 0, 32'h0,   32'h0, 0, 0, 0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0);   // BOOT
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h4, 1, 0, 0);   // pending discarded
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h8, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pc !== e.pc)       begin n_bad++; $display("FAIL rst_hold pc[%0d]: got %h want %h", k, o.pc, e.pc); end
      n_cmp++; if (o.fv !== e.fv)       begin n_bad++; $display("FAIL rst_hold fetch_valid[%0d]: got %b want %b", k, o.fv, e.fv); end
      n_cmp++; if (o.mis !== e.mis)     begin n_bad++; $display("FAIL rst_hold misaligned[%0d]: got %b want %b", k, o.mis, e.mis); end
      n_cmp++; if (o.flush !== e.flush) begin n_bad++; $display("FAIL rst_hold flush[%0d]: got %b want %b", k, o.flush, e.flush); end
      k++;
    end
  endtask

  task automatic test_misaligned();
    rec_t e, o;
    int k = 0;
    drive(1, 0, 0, 32'h0,   1, 32'h42,  32'h8, 0, 1, 0);
    drive(1, 0, 1, 32'h100, 0, 32'h0,   32'h8, 0, 1, 0);   // ERR ignores inputs
    drive(1, 0, 0, 32'h0,   1, 32'h200, 32'h8, 0, 1, 0);
    drive(1, 1, 1, 32'h44,  0, 32'h0,   32'h8, 0, 1, 0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h8, 0, 1, 0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h8, 0, 1, 0);
    drive(0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0);
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h4, 1, 0, 0);
    drive(1, 1, 1, 32'h13,  0, 32'h0,   32'h4, 0, 0, 0);   // misaligned parked
    drive(1, 0, 0, 32'h0,   0, 32'h0,   32'h4, 0, 1, 0);   // caught on release
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.pc !== e.pc)       begin n_bad++; $display("FAIL misalign pc[%0d]: got %h want %h", k, o.pc, e.pc); end
      n_cmp++; if (o.fv !== e.fv)       begin n_bad++; $display("FAIL misalign fetch_valid[%0d]: got %b want %b", k, o.fv, e.fv); end
      n_cmp++; if (o.mis !== e.mis)     begin n_bad++; $display("FAIL misalign misaligned[%0d]: got %b want %b", k, o.mis, e.mis); end
      n_cmp++; if (o.flush !== e.flush) begin n_bad++; $display("FAIL misalign flush[%0d]: got %b want %b", k, o.flush, e.flush); end
      k++;
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    test_reset();
    test_branch();
    test_stall_pending();
    test_back_to_back();
    test_reset_in_hold();
    test_misaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
